// File: rtl/sparse_read_arbiter.sv
// Shares the sparse refill buffer read port between NUM_REQ miss requesters using in-order tickets.
// Optional per-requester wait watchdog: define SPARSE_ARB_TIMEOUT_EN.
module sparse_read_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DEPTH       = 8,
    parameter int PTR_W       = 3,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  alloc_valid,
    output logic [NUM_REQ-1:0]  alloc_ready,
    output logic [NUM_REQ-1:0]  req_busy,
    input  logic [DEPTH-1:0]    buf_valid,
    output logic                buf_read_valid,
    output logic [PTR_W-1:0]    buf_read_ptr,
    input  logic                buf_read_enable,
    input  logic [DATA_W-1:0]   buf_read_data,
    output logic [NUM_REQ-1:0]  rsp_valid,
    output logic [DATA_W-1:0]   rsp_data
`ifdef SPARSE_ARB_TIMEOUT_EN
    ,
    output logic [NUM_REQ-1:0]  timeout_err
`endif
);

    localparam int RR_W  = $clog2(NUM_REQ);
    localparam int OUT_W = PTR_W + 1;

    typedef enum logic { REQ_IDLE, REQ_WAIT } req_state_e;
    typedef enum logic { ARB_IDLE, ARB_ISSUE } arb_state_e;

    req_state_e         req_state_q [NUM_REQ];
    req_state_e         req_state_d [NUM_REQ];
    logic [PTR_W-1:0]   tag_q [NUM_REQ];
    logic [PTR_W-1:0]   tag_d [NUM_REQ];
    arb_state_e         arb_state_q, arb_state_d;
    logic [RR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [RR_W-1:0]    winner_q, winner_d;
    logic [PTR_W-1:0]   alloc_ptr_q, alloc_ptr_d;
    logic [PTR_W-1:0]   read_ptr_q, read_ptr_d;
    logic [OUT_W-1:0]   outstanding_q, outstanding_d;
    logic               read_valid_q, read_valid_d;

    logic [NUM_REQ-1:0] eligible_s;
    logic [NUM_REQ-1:0] alloc_grant_s;
    logic               alloc_any_s;
    logic               handshake_s;
    logic [RR_W-1:0]    pick_s;
    logic               pick_found_s;

    // Eligibility, ticket allocation and the round-robin pick
    always_comb begin
        alloc_grant_s = '0;
        pick_s        = rr_ptr_q;
        pick_found_s  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible_s[i] = (req_state_q[i] == REQ_WAIT) && buf_valid[tag_q[i]];
        end
        // One slot is kept free so the count mirrors the buffer's own full rule
        if (!rst && (outstanding_q < OUT_W'(DEPTH - 1))) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (alloc_valid[i] && (req_state_q[i] == REQ_IDLE) && (alloc_grant_s == '0)) begin
                    alloc_grant_s[i] = 1'b1;
                end else begin
                    alloc_grant_s[i] = alloc_grant_s[i];
                end
            end
        end else begin
            alloc_grant_s = '0;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_found_s && eligible_s[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                pick_s       = RR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
                pick_found_s = 1'b1;
            end else begin
                pick_s       = pick_s;
            end
        end
    end

    assign alloc_any_s = |alloc_grant_s;
    assign alloc_ready = alloc_grant_s;
    assign handshake_s = read_valid_q && buf_read_enable;

    // Data return is a same-cycle pass-through of the buffer's combinational read data
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = handshake_s && (winner_q == RR_W'(i));
            req_busy[i]  = (req_state_q[i] != REQ_IDLE);
        end
        if (handshake_s) begin
            rsp_data = buf_read_data;
        end else begin
            rsp_data = '0;
        end
    end

    // Next-state for requesters, counters and the arbiter
    always_comb begin
        req_state_d   = req_state_q;
        tag_d         = tag_q;
        arb_state_d   = arb_state_q;
        rr_ptr_d      = rr_ptr_q;
        winner_d      = winner_q;
        read_ptr_d    = read_ptr_q;
        read_valid_d  = read_valid_q;
        alloc_ptr_d   = alloc_ptr_q;
        outstanding_d = outstanding_q;

        for (int i = 0; i < NUM_REQ; i++) begin
            if (alloc_grant_s[i]) begin
                req_state_d[i] = REQ_WAIT;
                tag_d[i]       = alloc_ptr_q;
            end else if (handshake_s && (winner_q == RR_W'(i))) begin
                req_state_d[i] = REQ_IDLE;
            end else begin
                req_state_d[i] = req_state_q[i];
            end
        end

        if (alloc_any_s) begin
            alloc_ptr_d = (alloc_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : alloc_ptr_q + PTR_W'(1);
        end else begin
            alloc_ptr_d = alloc_ptr_q;
        end

        case ({alloc_any_s, handshake_s})
            2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
            2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        case (arb_state_q)
            ARB_IDLE: begin
                if (pick_found_s) begin
                    arb_state_d  = ARB_ISSUE;
                    winner_d     = pick_s;
                    read_ptr_d   = tag_q[pick_s];
                    read_valid_d = 1'b1;
                end else begin
                    arb_state_d  = ARB_IDLE;
                end
            end
            ARB_ISSUE: begin
                if (handshake_s) begin
                    arb_state_d  = ARB_IDLE;
                    read_ptr_d   = '0;
                    read_valid_d = 1'b0;
                    rr_ptr_d     = (winner_q == RR_W'(NUM_REQ - 1)) ? '0 : winner_q + RR_W'(1);
                end else begin
                    arb_state_d  = ARB_ISSUE;
                end
            end
            default: begin
                arb_state_d  = ARB_IDLE;
                read_ptr_d   = '0;
                read_valid_d = 1'b0;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_state_q[i] <= REQ_IDLE;
                tag_q[i]       <= '0;
            end
            arb_state_q   <= ARB_IDLE;
            rr_ptr_q      <= '0;
            winner_q      <= '0;
            read_ptr_q    <= '0;
            read_valid_q  <= 1'b0;
            alloc_ptr_q   <= '0;
            outstanding_q <= '0;
        end else begin
            req_state_q   <= req_state_d;
            tag_q         <= tag_d;
            arb_state_q   <= arb_state_d;
            rr_ptr_q      <= rr_ptr_d;
            winner_q      <= winner_d;
            read_ptr_q    <= read_ptr_d;
            read_valid_q  <= read_valid_d;
            alloc_ptr_q   <= alloc_ptr_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign buf_read_valid = read_valid_q;
    assign buf_read_ptr   = read_ptr_q;

`ifdef SPARSE_ARB_TIMEOUT_EN
    logic [7:0]         wait_cnt_q [NUM_REQ];
    logic [7:0]         wait_cnt_d [NUM_REQ];
    logic [NUM_REQ-1:0] timeout_err_q, timeout_err_d;

    // Wait counter equals the 0-based cycle index within WAIT; the flag appears when it hits TIMEOUT_CYC
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (alloc_grant_s[i]) begin
                wait_cnt_d[i] = 8'd0;
            end else if ((req_state_q[i] == REQ_WAIT) && (wait_cnt_q[i] != 8'hFF)) begin
                wait_cnt_d[i] = wait_cnt_q[i] + 8'd1;
            end else begin
                wait_cnt_d[i] = wait_cnt_q[i];
            end
            timeout_err_d[i] = timeout_err_q[i] ||
                               ((req_state_q[i] == REQ_WAIT) && (wait_cnt_q[i] == 8'(TIMEOUT_CYC - 1)));
        end
    end

    // Watchdog registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt_q[i] <= 8'd0;
            end
            timeout_err_q <= '0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`endif

endmodule
